// File: rtl/d2_decoder_if.sv
// rtl/d2_decoder_if.sv - select/enable inputs and one-hot select outputs of d2_decoder
interface d2_decoder_if;
    logic en;
    logic a;
    logic b;
    logic y1;
    logic y2;
    logic y3;
    logic y4;
    logic valid;

    modport master (
        output en, a, b,
        input  y1, y2, y3, y4, valid
    );

    modport slave (
        input  en, a, b,
        output y1, y2, y3, y4, valid
    );
endinterface

// File: rtl/d2_decoder.sv
// rtl/d2_decoder.sv - clocked 2-to-4 one-hot decoder with valid flag
module d2_decoder #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit REGISTERED     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    d2_decoder_if.slave   bus
);

    // Internal vector is active-high with bit 0 = y1; polarity is applied last.
    logic [3:0] dec_y;
    logic [3:0] y_act;
    logic       valid_act;

    always_comb begin
        dec_y = 4'b0000;
        if (bus.en) begin
            case ({bus.a, bus.b})
                2'b00:   dec_y = 4'b0001;
                2'b01:   dec_y = 4'b0010;
                2'b10:   dec_y = 4'b0100;
                default: dec_y = 4'b1000;
            endcase
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [3:0] y_q;
            logic       valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q     <= 4'b0000;
                    valid_q <= 1'b0;
                end else begin
                    y_q     <= dec_y;
                    valid_q <= bus.en;
                end
            end

            assign y_act     = y_q;
            assign valid_act = valid_q;
        end else begin : g_comb
            // Reset still forces the idle state even without a register stage.
            assign y_act     = rst ? 4'b0000 : dec_y;
            assign valid_act = rst ? 1'b0 : bus.en;
        end
    endgenerate

    assign bus.y1    = y_act[0] ^ OUT_ACTIVE_LOW;
    assign bus.y2    = y_act[1] ^ OUT_ACTIVE_LOW;
    assign bus.y3    = y_act[2] ^ OUT_ACTIVE_LOW;
    assign bus.y4    = y_act[3] ^ OUT_ACTIVE_LOW;
    assign bus.valid = valid_act;

endmodule

// File: tb/tb_d2_decoder.sv
// tb/tb_d2_decoder.sv - directed bench for registered, active-low and combinational d2_decoder builds
module tb_d2_decoder;
    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    d2_decoder_if bus_reg ();
    d2_decoder_if bus_low ();
    d2_decoder_if bus_comb ();

    d2_decoder #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(bus_reg.slave));
    d2_decoder #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) u_low  (.clk(clk), .rst(rst), .bus(bus_low.slave));
    d2_decoder #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus_comb.slave));

    // y1y2y3y4 in display order, MSB = y1
    logic [3:0] y_reg, y_low, y_comb;
    assign y_reg  = {bus_reg.y1,  bus_reg.y2,  bus_reg.y3,  bus_reg.y4};
    assign y_low  = {bus_low.y1,  bus_low.y2,  bus_low.y3,  bus_low.y4};
    assign y_comb = {bus_comb.y1, bus_comb.y2, bus_comb.y3, bus_comb.y4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic a, input logic b);
        bus_reg.en  = en; bus_reg.a  = a; bus_reg.b  = b;
        bus_low.en  = en; bus_low.a  = a; bus_low.b  = b;
        bus_comb.en = en; bus_comb.a = a; bus_comb.b = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        #2;
        nvec++;
        if (y_reg !== 4'b0000 || bus_reg.valid !== 1'b0) begin
            nmis++; $display("FAIL reset_reg: y=%b valid=%b, expected y=0000 valid=0", y_reg, bus_reg.valid);
        end
        nvec++;
        if (y_low !== 4'b1111 || bus_low.valid !== 1'b0) begin
            nmis++; $display("FAIL reset_low: y=%b valid=%b, expected y=1111 valid=0", y_low, bus_low.valid);
        end
        nvec++;
        if (y_comb !== 4'b0000 || bus_comb.valid !== 1'b0) begin
            nmis++; $display("FAIL reset_comb: y=%b valid=%b, expected y=0000 valid=0", y_comb, bus_comb.valid);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (y_reg !== 4'b0001 || bus_reg.valid !== 1'b1) begin
            nmis++; $display("FAIL reset_release: y=%b valid=%b, expected y=0001 valid=1", y_reg, bus_reg.valid);
        end
    endtask

    task automatic test_sweep;
        logic [3:0] exp_y;
        logic [3:0] prev_y;
        logic [1:0] sel;
        prev_y = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            sel   = 2'(i);
            exp_y = 4'b1000 >> i;
            drive(1'b1, sel[1], sel[0]);
            #1;
            nvec++;
            if (y_comb !== exp_y || bus_comb.valid !== 1'b1) begin
                nmis++; $display("FAIL sweep_comb sel=%b: y=%b valid=%b, expected y=%b valid=1", sel, y_comb, bus_comb.valid, exp_y);
            end
            nvec++;
            if (y_reg !== prev_y) begin
                nmis++; $display("FAIL sweep_latency sel=%b: y=%b before edge, expected %b", sel, y_reg, prev_y);
            end
            @(negedge clk);
            nvec++;
            if (y_reg !== exp_y || bus_reg.valid !== 1'b1) begin
                nmis++; $display("FAIL sweep_reg sel=%b: y=%b valid=%b, expected y=%b valid=1", sel, y_reg, bus_reg.valid, exp_y);
            end
            nvec++;
            if (y_low !== ~exp_y || bus_low.valid !== 1'b1) begin
                nmis++; $display("FAIL sweep_low sel=%b: y=%b valid=%b, expected y=%b valid=1", sel, y_low, bus_low.valid, ~exp_y);
            end
            prev_y = exp_y;
        end
    endtask

    task automatic test_enable_gating;
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++;
            if (y_reg !== 4'b0000 || bus_reg.valid !== 1'b0) begin
                nmis++; $display("FAIL gate_reg cyc%0d: y=%b valid=%b, expected y=0000 valid=0", i, y_reg, bus_reg.valid);
            end
            nvec++;
            if (y_low !== 4'b1111 || bus_low.valid !== 1'b0) begin
                nmis++; $display("FAIL gate_low cyc%0d: y=%b valid=%b, expected y=1111 valid=0", i, y_low, bus_low.valid);
            end
            nvec++;
            if (y_comb !== 4'b0000 || bus_comb.valid !== 1'b0) begin
                nmis++; $display("FAIL gate_comb cyc%0d: y=%b valid=%b, expected y=0000 valid=0", i, y_comb, bus_comb.valid);
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        nvec++;
        if (y_reg !== 4'b0010 || bus_reg.valid !== 1'b1) begin
            nmis++; $display("FAIL gate_enable: y=%b valid=%b, expected y=0010 valid=1", y_reg, bus_reg.valid);
        end
    endtask

    task automatic test_mid_reset;
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        nvec++;
        if (y_reg !== 4'b0100 || bus_reg.valid !== 1'b1) begin
            nmis++; $display("FAIL midrst_pre: y=%b valid=%b, expected y=0100 valid=1", y_reg, bus_reg.valid);
        end
        nvec++;
        if (y_low !== 4'b1011) begin
            nmis++; $display("FAIL midrst_low_pre: y=%b, expected 1011", y_low);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if (y_reg !== 4'b0000 || bus_reg.valid !== 1'b0) begin
            nmis++; $display("FAIL midrst_reg: y=%b valid=%b, expected y=0000 valid=0", y_reg, bus_reg.valid);
        end
        nvec++;
        if (y_low !== 4'b1111 || bus_low.valid !== 1'b0) begin
            nmis++; $display("FAIL midrst_low: y=%b valid=%b, expected y=1111 valid=0", y_low, bus_low.valid);
        end
        nvec++;
        if (y_comb !== 4'b0000 || bus_comb.valid !== 1'b0) begin
            nmis++; $display("FAIL midrst_comb: y=%b valid=%b, expected y=0000 valid=0", y_comb, bus_comb.valid);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (y_reg !== 4'b0100 || bus_reg.valid !== 1'b1) begin
            nmis++; $display("FAIL midrst_restore: y=%b valid=%b, expected y=0100 valid=1", y_reg, bus_reg.valid);
        end
    endtask

    task automatic test_comb_change;
        drive(1'b1, 1'b0, 1'b0);
        #1;
        nvec++;
        if (y_comb !== 4'b1000 || bus_comb.valid !== 1'b1) begin
            nmis++; $display("FAIL comb_00: y=%b valid=%b, expected y=1000 valid=1", y_comb, bus_comb.valid);
        end
        drive(1'b1, 1'b1, 1'b1);
        #1;
        nvec++;
        if (y_comb !== 4'b0001 || bus_comb.valid !== 1'b1) begin
            nmis++; $display("FAIL comb_11: y=%b valid=%b, expected y=0001 valid=1", y_comb, bus_comb.valid);
        end
        drive(1'b0, 1'b1, 1'b1);
        #1;
        nvec++;
        if (y_comb !== 4'b0000 || bus_comb.valid !== 1'b0) begin
            nmis++; $display("FAIL comb_en0: y=%b valid=%b, expected y=0000 valid=0", y_comb, bus_comb.valid);
        end
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        test_reset();
        test_sweep();
        test_enable_gating();
        test_mid_reset();
        test_comb_change();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
